matmul_sequencer: RTL and testbench
===================================

Name: matmul_sequencer

Overview:
- Control block for the 8-bit matrix-multiply datapath in the FPGA fabric. It sits behind the HPS lightweight-bridge register file, which supplies start, dim and abort.
- Computes C = A x B for square matrices of run-time dimension N (1..MAX_DIM).
- Generates read addresses for the A and B operand RAMs, and clear/enable strobes for the external MAC unit.
- Issues C result-RAM write strobes, then reports busy, done and a sticky interrupt to the HPS.

Parameters:
- MAX_DIM, 8: largest supported N; must be a power of two.
- IDX_W, 3: clog2(MAX_DIM); width of the row/column/k indices.
- RAM_LAT, 1: operand-RAM read latency in cycles (1..4).

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run when idle.
- abort  in  1  one-cycle pulse; cancels a run.
- dim  in  IDX_W+1  matrix dimension N; sampled on an accepted start.
- irq_ack  in  1  clears irq.
- a_addr  out  2*IDX_W  A read address {i,k}.
- b_addr  out  2*IDX_W  B read address {k,j}.
- mac_clr  out  1  the MAC loads the product instead of accumulating; aligned with mac_en.
- mac_en  out  1  operand data valid at the MAC this cycle.
- c_addr  out  2*IDX_W  C write address {i,j}.
- c_we  out  1  write the accumulator to C.
- busy  out  1  a run is in progress.
- done  out  1  one-cycle pulse at run completion.
- irq  out  1  sticky completion flag.
- err  out  1  sticky flag: last start was rejected.

Behaviour:
- Reset: all outputs are 0, state is IDLE, indices i/j/k are 0, and the issue pipeline is flushed. Reset takes effect immediately and asynchronously, also mid-run.
- Addressing: row-major with stride MAX_DIM, so an address is the concatenation of two IDX_W indices. No multiplier is used.
- States: IDLE, ISSUE, WAIT, WRITE, DONE.
- IDLE, start=1 and 1<=dim<=MAX_DIM:
  - Latch N=dim, set i=j=k=0, clear err and irq.
  - Next state is ISSUE.
- IDLE, start=1 with dim=0 or dim>MAX_DIM: set err, stay in IDLE.
- start while not in IDLE: ignored, with no effect on err.
- ISSUE: drive a_addr={i,k} and b_addr={k,j}, and push a valid token (first = (k==0)) into the delay line.
  - k increments each cycle.
  - After k=N-1, k resets to 0 and the next state is WAIT.
- Delay line (RAM_LAT stages): mac_en = token valid and mac_clr = token first, both RAM_LAT cycles after the address.
- WAIT: lasts exactly RAM_LAT cycles, then the next state is WRITE.
- WRITE: lasts one cycle, with c_we=1 and c_addr={i,j}. The accumulator is valid here because the last mac_en occurred in the previous cycle.
  - Then j increments. On wrap, j=0 and i increments.
  - If i=N-1 and j=N-1, the next state is DONE; otherwise ISSUE.
- DONE: lasts one cycle with done=1 and irq set, then the next state is IDLE.
- busy = 1 in ISSUE, WAIT, WRITE and DONE. busy is registered, so it rises the cycle after start is accepted.
- Cycle count per C element: N+RAM_LAT+1. Total busy cycles: N*N*(N+RAM_LAT+1)+1.
- abort in any non-IDLE state:
  - Next state is IDLE and the delay line is flushed, so no mac_en follows.
  - c_we is not asserted, and no done or irq is raised.
  - abort in IDLE has no effect.
- abort and start in the same cycle: abort wins, and start is ignored.
- irq clears on irq_ack.
- irq_ack in the same cycle as irq set: set wins.
- a_addr, b_addr and c_addr hold their last values when not in use. They are don't-care outside their strobes, but must never be X after reset.

Decomposition:
- Package matmul_pkg:
  - state enum {IDLE, ISSUE, WAIT, WRITE, DONE}.
  - MAX_DIM, IDX_W and RAM_LAT defaults.
  - Address-width constant 2*IDX_W.
- Sub-module matmul_issue_pipe: a RAM_LAT-deep shift register carrying {valid, first}, with a synchronous flush input and asynchronous reset.

Test Plan:
- N=2, RAM_LAT=1, start at cycle 0:
  - busy high for cycles 1..17.
  - c_we at cycles 4, 8, 12, 16 with c_addr 0, 1, 8, 9.
  - done at cycle 17 and irq high from cycle 18.
- N=1: a_addr=b_addr=0; mac_en+mac_clr one cycle after ISSUE; c_we two cycles later at c_addr=0; done follows.
- dim=0, then dim=9: err=1, busy stays 0, no strobes; then a valid start with dim=3 clears err.
- N=3, abort during the second WRITE: c_we low that cycle, busy low next cycle, no further mac_en, done/irq never set.
- N=2, start pulsed mid-run: ignored, and the run completes with identical timing; irq_ack then clears irq.
- Reset asserted mid-ISSUE (N=4): all outputs are 0 immediately; a restart with N=2 then matches the first scenario's timing.
- Reference-model check, N=8 with random A/B through the RAM and MAC models: the C contents match the golden product.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types and default sizing for the matrix-multiply sequencer.
// State encoding and address width are common to the control block and its interface.
package matmul_pkg;

  localparam int DEF_MAX_DIM = 8;
  localparam int DEF_IDX_W   = 3;
  localparam int DEF_RAM_LAT = 1;
  localparam int ADDR_W      = 2 * DEF_IDX_W;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    WRITE,
    DONE
  } state_t;

endpackage

// File: rtl/matmul_if.sv
// Register-file / datapath bundle for the matmul sequencer.
// The master side is the HPS register file; the slave side is the sequencer.
interface matmul_if #(
  parameter int IDX_W = matmul_pkg::DEF_IDX_W
);
  localparam int AW = 2 * IDX_W;

  logic           start;
  logic           abort;
  logic [IDX_W:0] dim;
  logic           irq_ack;
  logic [AW-1:0]  a_addr;
  logic [AW-1:0]  b_addr;
  logic           mac_clr;
  logic           mac_en;
  logic [AW-1:0]  c_addr;
  logic           c_we;
  logic           busy;
  logic           done;
  logic           irq;
  logic           err;

  modport master (
    output start, abort, dim, irq_ack,
    input  a_addr, b_addr, mac_clr, mac_en, c_addr, c_we, busy, done, irq, err
  );

  modport slave (
    input  start, abort, dim, irq_ack,
    output a_addr, b_addr, mac_clr, mac_en, c_addr, c_we, busy, done, irq, err
  );

endinterface

// File: rtl/matmul_issue_pipe.sv
// Delay line that re-times each issued {valid, first} token to the cycle the
// operand RAM data reaches the MAC.
module matmul_issue_pipe
  import matmul_pkg::*;
#(
  parameter int LAT = DEF_RAM_LAT
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic in_valid,
  input  logic in_first,
  output logic out_valid,
  output logic out_first
);

  logic [LAT-1:0] valid_q, valid_d;
  logic [LAT-1:0] first_q, first_d;

  always_comb begin
    valid_d = '0;
    first_d = '0;
    if (!flush) begin
      valid_d[0] = in_valid;
      first_d[0] = in_valid && in_first;
      for (int s = 1; s < LAT; s++) begin
        valid_d[s] = valid_q[s-1];
        first_d[s] = first_q[s-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      first_q <= '0;
    end else begin
      valid_q <= valid_d;
      first_q <= first_d;
    end
  end

  assign out_valid = valid_q[LAT-1];
  assign out_first = first_q[LAT-1];

endmodule

// File: rtl/matmul_sequencer.sv
// Control FSM for C = A x B: walks i/j/k, issues operand addresses, strobes
// the MAC and the C write port, and reports busy/done/irq/err.
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int MAX_DIM = DEF_MAX_DIM,
  parameter int IDX_W   = DEF_IDX_W,
  parameter int RAM_LAT = DEF_RAM_LAT
) (
  input  logic    clk,
  input  logic    reset,
  matmul_if.slave bus
);

  localparam int             AW        = 2 * IDX_W;
  localparam logic [IDX_W:0] DIM_MAX   = (IDX_W + 1)'(MAX_DIM);
  localparam logic [2:0]     WAIT_LAST = 3'(RAM_LAT - 1);

  state_t state_q, state_d;
  logic [IDX_W-1:0] i_q, i_d, j_q, j_d, k_q, k_d, n_last_q, n_last_d;
  logic [2:0] wait_q, wait_d;
  logic [AW-1:0] a_addr_q, a_addr_d, b_addr_q, b_addr_d, c_addr_q, c_addr_d;
  logic c_we_q, c_we_d, busy_q, busy_d, done_q, done_d;
  logic irq_q, irq_d, err_q, err_d;
  logic dim_ok, start_ok, run_abort;

  always_comb begin
    dim_ok    = (bus.dim != '0) && (bus.dim <= DIM_MAX);
    start_ok  = bus.start && !bus.abort && (state_q == IDLE);
    run_abort = bus.abort && (state_q != IDLE);

    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    n_last_d = n_last_q;
    wait_d   = wait_q;
    err_d    = err_q;
    irq_d    = irq_q;
    if (bus.irq_ack) irq_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_ok) begin
          if (dim_ok) begin
            n_last_d = bus.dim[IDX_W-1:0] - IDX_W'(1);
            i_d      = '0;
            j_d      = '0;
            k_d      = '0;
            err_d    = 1'b0;
            irq_d    = 1'b0;
            state_d  = ISSUE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (k_q == n_last_q) begin
          k_d     = '0;
          wait_d  = '0;
          state_d = WAIT;
        end else begin
          k_d = k_q + IDX_W'(1);
        end
      end
      WAIT: begin
        if (wait_q == WAIT_LAST) state_d = WRITE;
        else wait_d = wait_q + 3'd1;
      end
      WRITE: begin
        state_d = ISSUE;
        if (j_q == n_last_q) begin
          j_d = '0;
          if (i_q == n_last_q) begin
            i_d     = '0;
            state_d = DONE;
          end else begin
            i_d = i_q + IDX_W'(1);
          end
        end else begin
          j_d = j_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (!bus.abort) irq_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (run_abort) state_d = IDLE;

    // Outputs are registered against the next state so they line up with it.
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
    c_we_d   = (state_d == WRITE);
    a_addr_d = a_addr_q;
    b_addr_d = b_addr_q;
    c_addr_d = c_addr_q;
    if (state_d == ISSUE) begin
      a_addr_d = {i_d, k_d};
      b_addr_d = {k_d, j_d};
    end
    if (state_d == WRITE) c_addr_d = {i_d, j_d};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      n_last_q <= '0;
      wait_q   <= '0;
      a_addr_q <= '0;
      b_addr_q <= '0;
      c_addr_q <= '0;
      c_we_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      irq_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      n_last_q <= n_last_d;
      wait_q   <= wait_d;
      a_addr_q <= a_addr_d;
      b_addr_q <= b_addr_d;
      c_addr_q <= c_addr_d;
      c_we_q   <= c_we_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      irq_q    <= irq_d;
      err_q    <= err_d;
    end
  end

  matmul_issue_pipe #(
    .LAT(RAM_LAT)
  ) u_issue_pipe (
    .clk      (clk),
    .reset    (reset),
    .flush    (run_abort),
    .in_valid (state_q == ISSUE),
    .in_first (k_q == '0),
    .out_valid(bus.mac_en),
    .out_first(bus.mac_clr)
  );

  // An abort landing on a WRITE or DONE cycle suppresses that cycle's strobe.
  assign bus.c_we   = c_we_q & ~bus.abort;
  assign bus.done   = done_q & ~bus.abort;
  assign bus.a_addr = a_addr_q;
  assign bus.b_addr = b_addr_q;
  assign bus.c_addr = c_addr_q;
  assign bus.busy   = busy_q;
  assign bus.irq    = irq_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer with operand-RAM and MAC models for
// an end-to-end product check.
module tb_matmul_sequencer;
  import matmul_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;

  matmul_if #(.IDX_W(DEF_IDX_W)) bus ();

  matmul_sequencer #(
    .MAX_DIM(DEF_MAX_DIM),
    .IDX_W  (DEF_IDX_W),
    .RAM_LAT(DEF_RAM_LAT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // One-cycle-latency operand RAMs, the MAC, and the C result RAM.
  logic [7:0]  a_mem [64];
  logic [7:0]  b_mem [64];
  logic [31:0] c_mem [64];
  logic [31:0] golden [64];
  logic [7:0]  a_rd, b_rd;
  logic [31:0] acc;

  always @(posedge clk) begin
    a_rd <= a_mem[bus.a_addr];
    b_rd <= b_mem[bus.b_addr];
    if (bus.mac_en)
      acc <= bus.mac_clr ? {24'd0, a_rd} * {24'd0, b_rd} : acc + {24'd0, a_rd} * {24'd0, b_rd};
    if (bus.c_we) c_mem[bus.c_addr] <= acc;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic [3:0] d, input logic ack);
    bus.start   = s;
    bus.abort   = a;
    bus.dim     = d;
    bus.irq_ack = ack;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checkOutput(tag, {31'd0, obs}, {31'd0, exp});
  endtask

  // Full N=2 run started from IDLE; hand timing: 4 cycles per element, done at 17.
  task automatic runN2(input string tag, input bit midStart);
    int cexp [4] = '{0, 1, 8, 9};
    int e, r;
    applyStimulus(1'b1, 1'b0, 4'd2, 1'b0);
    for (int c = 1; c <= 18; c++) begin
      step();
      if (midStart && c == 6) applyStimulus(1'b1, 1'b0, 4'd3, 1'b0);
      else applyStimulus(1'b0, 1'b0, 4'd2, 1'b0);
      e = (c - 1) / 4;
      r = (c - 1) % 4;
      checkBit($sformatf("%s busy@%0d", tag, c), bus.busy, c <= 17);
      checkBit($sformatf("%s c_we@%0d", tag, c), bus.c_we, c <= 16 && r == 3);
      checkBit($sformatf("%s mac_en@%0d", tag, c), bus.mac_en, c <= 16 && (r == 1 || r == 2));
      checkBit($sformatf("%s mac_clr@%0d", tag, c), bus.mac_clr, c <= 16 && r == 1);
      checkBit($sformatf("%s done@%0d", tag, c), bus.done, c == 17);
      checkBit($sformatf("%s irq@%0d", tag, c), bus.irq, c == 18);
      if (c <= 16 && r == 3)
        checkOutput($sformatf("%s c_addr@%0d", tag, c), 32'(bus.c_addr), cexp[e]);
      if (c <= 16 && r < 2) begin
        checkOutput($sformatf("%s a_addr@%0d", tag, c), 32'(bus.a_addr), (e / 2) * 8 + r);
        checkOutput($sformatf("%s b_addr@%0d", tag, c), 32'(bus.b_addr), r * 8 + (e % 2));
      end
    end
    checkBit({tag, " err"}, bus.err, 1'b0);
  endtask

  initial begin
    int cnt;
    int busyCnt;
    bit doneSeen;
    logic [31:0] sum;

    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
    #10;
    checkBit("rst busy", bus.busy, 1'b0);
    checkBit("rst done", bus.done, 1'b0);
    checkBit("rst irq", bus.irq, 1'b0);
    checkBit("rst err", bus.err, 1'b0);
    checkBit("rst mac_en", bus.mac_en, 1'b0);
    checkBit("rst c_we", bus.c_we, 1'b0);
    checkOutput("rst a_addr", 32'(bus.a_addr), 0);
    checkOutput("rst c_addr", 32'(bus.c_addr), 0);
    @(negedge clk) reset = 1'b0;
    step();

    $display("[TB] N=2 basic run");
    runN2("n2", 1'b0);

    $display("[TB] N=1 run with irq_ack colliding with irq set");
    applyStimulus(1'b1, 1'b0, 4'd1, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 4'd1, 1'b0);
    checkBit("n1 busy", bus.busy, 1'b1);
    checkBit("n1 irq cleared by start", bus.irq, 1'b0);
    checkOutput("n1 a_addr", 32'(bus.a_addr), 0);
    checkOutput("n1 b_addr", 32'(bus.b_addr), 0);
    step();
    checkBit("n1 mac_en", bus.mac_en, 1'b1);
    checkBit("n1 mac_clr", bus.mac_clr, 1'b1);
    step();
    checkBit("n1 c_we", bus.c_we, 1'b1);
    checkOutput("n1 c_addr", 32'(bus.c_addr), 0);
    checkBit("n1 mac_en after", bus.mac_en, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 4'd1, 1'b1);
    checkBit("n1 done", bus.done, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 4'd1, 1'b0);
    checkBit("n1 irq set wins", bus.irq, 1'b1);
    checkBit("n1 idle", bus.busy, 1'b0);

    $display("[TB] rejected dims, then N=3 abort in WRITE");
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
    checkBit("dim0 err", bus.err, 1'b1);
    checkBit("dim0 busy", bus.busy, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'd9, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 4'd9, 1'b0);
    checkBit("dim9 err", bus.err, 1'b1);
    cnt = 0;
    for (int c = 0; c < 3; c++) begin
      cnt += int'(bus.busy) + int'(bus.mac_en) + int'(bus.c_we) + int'(bus.done);
      step();
    end
    checkOutput("dim9 no strobes", cnt, 0);
    applyStimulus(1'b1, 1'b0, 4'd3, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 4'd3, 1'b0);
    checkBit("dim3 err cleared", bus.err, 1'b0);
    checkBit("dim3 busy", bus.busy, 1'b1);
    checkBit("dim3 irq cleared", bus.irq, 1'b0);
    for (int c = 2; c <= 10; c++) begin
      step();
      if (c == 5) begin
        checkBit("n3 first c_we", bus.c_we, 1'b1);
        checkOutput("n3 first c_addr", 32'(bus.c_addr), 0);
      end
    end
    checkBit("n3 second c_we", bus.c_we, 1'b1);
    checkOutput("n3 second c_addr", 32'(bus.c_addr), 1);
    applyStimulus(1'b0, 1'b1, 4'd3, 1'b0);
    checkBit("n3 abort masks c_we", bus.c_we, 1'b0);
    checkBit("n3 busy during abort", bus.busy, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 4'd3, 1'b0);
    checkBit("n3 busy after abort", bus.busy, 1'b0);
    cnt = 0;
    for (int c = 0; c < 30; c++) begin
      cnt += int'(bus.busy) + int'(bus.mac_en) + int'(bus.c_we) + int'(bus.done) + int'(bus.irq);
      step();
    end
    checkOutput("n3 quiet after abort", cnt, 0);

    applyStimulus(1'b1, 1'b0, 4'd2, 1'b0);
    step();
    applyStimulus(1'b0, 1'b1, 4'd2, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 4'd2, 1'b0);
    checkBit("issue abort flushes mac_en", bus.mac_en, 1'b0);
    checkBit("issue abort busy", bus.busy, 1'b0);
    applyStimulus(1'b1, 1'b1, 4'd2, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 4'd2, 1'b0);
    checkBit("start+abort ignored", bus.busy, 1'b0);

    $display("[TB] N=2 run with stray start, then irq_ack");
    runN2("n2mid", 1'b1);
    applyStimulus(1'b0, 1'b0, 4'd2, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 4'd2, 1'b0);
    checkBit("irq_ack clears", bus.irq, 1'b0);

    $display("[TB] reset mid ISSUE at N=4");
    applyStimulus(1'b1, 1'b0, 4'd4, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 4'd4, 1'b0);
    step();
    checkBit("n4 mac_en before reset", bus.mac_en, 1'b1);
    checkOutput("n4 a_addr before reset", 32'(bus.a_addr), 1);
    #2 reset = 1'b1;
    #1;
    checkBit("midrst busy", bus.busy, 1'b0);
    checkBit("midrst mac_en", bus.mac_en, 1'b0);
    checkBit("midrst mac_clr", bus.mac_clr, 1'b0);
    checkBit("midrst c_we", bus.c_we, 1'b0);
    checkOutput("midrst a_addr", 32'(bus.a_addr), 0);
    checkOutput("midrst b_addr", 32'(bus.b_addr), 0);
    @(negedge clk) reset = 1'b0;
    step();
    runN2("n2rst", 1'b0);

    $display("[TB] N=8 random product");
    for (int x = 0; x < 64; x++) begin
      a_mem[x] = 8'($urandom_range(0, 255));
      b_mem[x] = 8'($urandom_range(0, 255));
    end
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        sum = '0;
        for (int k = 0; k < 8; k++)
          sum += {24'd0, a_mem[i*8+k]} * {24'd0, b_mem[k*8+j]};
        golden[i*8+j] = sum;
      end
    end
    applyStimulus(1'b1, 1'b0, 4'd8, 1'b0);
    busyCnt = 0;
    doneSeen = 1'b0;
    for (int c = 1; c <= 2000 && !doneSeen; c++) begin
      step();
      applyStimulus(1'b0, 1'b0, 4'd8, 1'b0);
      if (bus.busy) busyCnt++;
      if (bus.done) doneSeen = 1'b1;
    end
    checkBit("n8 done seen", doneSeen, 1'b1);
    checkOutput("n8 busy cycles", busyCnt, 641);
    step();
    checkBit("n8 irq", bus.irq, 1'b1);
    for (int x = 0; x < 64; x++)
      checkOutput($sformatf("n8 C[%0d]", x), c_mem[x], golden[x]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
